// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execution units.
// Holds the M-extension funct3 encodings and the multiply/divide sequencer states.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring divide,
// operating on operand magnitudes with the sign fixed up once the iteration completes.
module muldiv_unit #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  operand_a,
    input  logic [XLEN-1:0]  operand_b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out
);
    import riscv_pkg::*;

    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

    muldiv_state_t    state, state_next;
    logic [CNT_W-1:0] count;
    logic [2:0]       op;
    logic [4:0]       rd_hold;
    logic [XLEN-1:0]  acc_hi, acc_lo, mag_b_hold;
    logic             neg_res, neg_rem;

    logic             accept, a_signed, b_signed, a_neg, b_neg;
    logic             div_zero, div_ovf, fast;
    logic [XLEN-1:0]  mag_a, mag_b, fast_result;

    logic [XLEN:0]     sum, shifted, diff;
    logic [XLEN-1:0]   hi_next, lo_next;
    logic [2*XLEN-1:0] product, product_fix;
    logic [XLEN-1:0]   final_result;

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_FIN);
    assign accept = (state == ST_IDLE) && start && !flush;

    // Decode of the incoming request: signedness, magnitudes and the no-iteration cases.
    always_comb begin
        a_signed = (funct3 == MULDIV_MULH) || (funct3 == MULDIV_MULHSU) ||
                   (funct3 == MULDIV_DIV)  || (funct3 == MULDIV_REM);
        b_signed = (funct3 == MULDIV_MULH) || (funct3 == MULDIV_DIV) ||
                   (funct3 == MULDIV_REM);
        a_neg    = a_signed && operand_a[XLEN-1];
        b_neg    = b_signed && operand_b[XLEN-1];
        mag_a    = a_neg ? -operand_a : operand_a;
        mag_b    = b_neg ? -operand_b : operand_b;
        div_zero = funct3[2] && (operand_b == '0);
        div_ovf  = ((funct3 == MULDIV_DIV) || (funct3 == MULDIV_REM)) &&
                   (operand_a == MIN_NEG) && (operand_b == '1);
        fast     = div_zero || div_ovf;
        fast_result = '0;
        if (div_zero) begin
            fast_result = funct3[1] ? operand_a : '1;
        end else if (div_ovf) begin
            fast_result = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration step; the final result is taken from the post-step values so it
    // can be registered on the same edge that enters FIN.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b_hold} : '0);
        shifted = {acc_hi, acc_lo[XLEN-1]};
        diff    = shifted - {1'b0, mag_b_hold};
        if (op[2]) begin
            hi_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_next = {acc_lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], acc_lo[XLEN-1:1]};
        end
        product     = {hi_next, lo_next};
        product_fix = neg_res ? -product : product;
        case (op)
            MULDIV_MUL:               final_result = product_fix[XLEN-1:0];
            MULDIV_DIV, MULDIV_DIVU:  final_result = neg_res ? -lo_next : lo_next;
            MULDIV_REM, MULDIV_REMU:  final_result = neg_rem ? -hi_next : hi_next;
            default:                  final_result = product_fix[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = fast ? ST_FIN : ST_CALC;
            ST_CALC: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (count == LAST) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= '0;
            op         <= '0;
            rd_hold    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            mag_b_hold <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            result     <= '0;
            rd_out     <= '0;
        end else if (accept) begin
            count      <= '0;
            op         <= funct3;
            rd_hold    <= rd_in;
            acc_hi     <= '0;
            acc_lo     <= mag_a;
            mag_b_hold <= mag_b;
            neg_res    <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
            if (fast) begin
                result <= fast_result;
                rd_out <= rd_in;
            end
        end else if (state == ST_CALC && !flush) begin
            acc_hi <= hi_next;
            acc_lo <= lo_next;
            count  <= count + CNT_W'(1);
            if (count == LAST) begin
                result <= final_result;
                rd_out <= rd_hold;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, fast paths,
// ignored starts, flush and reset behaviour, checked with immediate assertions.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    // Presents a request for one cycle, then scrambles the inputs to prove they were latched.
    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd);
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        start     = 1'b1;
        next_cycle();
        start     = 1'b0;
        funct3    = ~f3;
        operand_a = ~a;
        operand_b = ~b;
        rd_in     = ~rd;
    endtask

    task automatic wait_done(input int max_cycles, output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge clock);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            @(posedge clock);
            #1;
        end
        next_cycle();
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_result, input int exp_lat);
        int   lat;
        logic bok;
        apply_stimulus(f3, a, b, rd);
        wait_done(40, lat, bok);
        check_output({tag, " result"}, result, exp_result);
        check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    endtask

    initial begin
        int   lat;
        logic bok;
        int   extra_done;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (2) next_cycle();
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset done", 32'(done), 32'd0);
        check_output("reset result", result, 32'd0);
        check_output("reset rd_out", 32'(rd_out), 32'd0);
        reset = 1'b0;
        next_cycle();

        $display("[TB] reset in the middle of an operation");
        apply_stimulus(3'b000, 32'd5, 32'd6, 5'd4);
        repeat (8) next_cycle();
        check_output("pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("mid reset busy", 32'(busy), 32'd0);
        check_output("mid reset done", 32'(done), 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        $display("[TB] MUL 7 * -3 with latency and busy tracking");
        apply_stimulus(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done(40, lat, bok);
        check_output("mul latency", 32'(lat), 32'd33);
        check_output("mul busy held", 32'(bok), 32'd1);
        check_output("mul result", result, 32'hFFFF_FFEB);
        check_output("mul rd_out", 32'(rd_out), 32'd5);
        check_output("mul done pulse", 32'(done), 32'd0);
        check_output("mul busy after", 32'(busy), 32'd0);

        $display("[TB] high-half multiplies and iterative divides");
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 33);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFD, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFF, 33);
        run_op("divu",   3'b101, 32'd100,       32'd7,         5'd8, 32'd14,        33);
        run_op("remu",   3'b111, 32'd100,       32'd7,         5'd9, 32'd2,         33);

        $display("[TB] fast paths");
        run_op("divu by0",  3'b101, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run_op("rem by0",   3'b110, 32'd5,         32'd0,         5'd11, 32'd5,         1);
        run_op("div ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1);
        run_op("rem ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1);

        $display("[TB] start during CALC is ignored");
        apply_stimulus(3'b101, 32'd100, 32'd7, 5'd3);
        repeat (9) next_cycle();
        funct3 = 3'b000; operand_a = 32'd2; operand_b = 32'd3; rd_in = 5'd9;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_done(40, lat, bok);
        check_output("ignored start latency", 32'(lat), 32'd23);
        check_output("ignored start result", result, 32'd14);
        check_output("ignored start rd_out", 32'(rd_out), 32'd3);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) extra_done++;
            next_cycle();
        end
        check_output("no second done", 32'(extra_done), 32'd0);

        $display("[TB] flush mid-operation, then restart");
        apply_stimulus(3'b000, 32'd9, 32'd9, 5'd20);
        repeat (4) next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        check_output("flush busy", 32'(busy), 32'd0);
        check_output("flush done", 32'(done), 32'd0);
        check_output("flush result kept", result, 32'd14);
        check_output("flush rd_out kept", 32'(rd_out), 32'd3);
        run_op("after flush", 3'b111, 32'd100, 32'd7, 5'd7, 32'd2, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read operands and produces a 32-bit result plus its destination index for the writeback path into the register file.
- Radix-2: one bit per cycle, shift-add multiply and restoring divide.
- Holds the pipeline via `busy` while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width; equals log2(XLEN).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- flush  input  1  abort the current operation; no `done` is produced.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  32  rs1 data (multiplicand / dividend).
- operand_b  input  32  rs2 data (multiplier / divisor).
- rd_in  input  5  destination register index.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; `result` is valid in that cycle.
- result  output  32  final value; held until the next accepted start.
- rd_out  output  5  captured `rd_in`; held with `result`.

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0; done=0; result=0; rd_out=0; counter=0; all internal accumulators=0.
- States: IDLE, CALC, FIN.
- IDLE to CALC: start=1 and flush=0. Latch funct3 and rd_in, plus the operand magnitudes and result-sign flags. Signedness per op:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
  - Remaining ops: unsigned.
- IDLE to FIN (fast path), taken when start=1 and either:
  - a divide op has operand_b==0, or
  - DIV/REM has a==0x80000000 and b==0xFFFFFFFF.
- CALC: exactly 32 cycles, counter 0..31. Each cycle performs one shift-add or one restoring-subtract step. At counter==31, go to FIN.
- FIN: done=1 for this cycle only; `result`/`rd_out` are registered on entry. Next state is always IDLE.
- Latency: start high in cycle N gives done in cycle N+33 (normal) or N+1 (fast path).
- start in CALC or FIN: ignored, not queued. Upstream must hold it until busy=0.
- Result selection:
  - MUL: low 32 bits of the 64-bit product.
  - MULH/MULHSU/MULHU: high 32 bits, with the sign applied to the full 64-bit product via two's complement before selection.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Divide by zero: DIV=DIVU=0xFFFFFFFF; REM=REMU=operand_a.
- Overflow (DIV/REM only): DIV=0x80000000; REM=0.
- flush=1 in any state: next state IDLE; done=0 next cycle; result/rd_out unchanged. flush takes priority over start in the same cycle.
- Reset mid-operation: immediate return to reset values; no done.
- Operands are sampled only at accept; later changes on operand_a/b have no effect.
- All arithmetic is unsigned internally on 33/64-bit accumulators; no truncation before final selection.

Decomposition:
- Shared package riscv_pkg:
  - XLEN;
  - funct3 constants MULDIV_MUL..MULDIV_REMU;
  - state encoding constants for IDLE/CALC/FIN.
- No sub-module: the sign-fixup and iteration datapath fit in a single module of about 200 lines.

Test Plan:
- Reset mid-CALC, then MUL 7*(-3) with start in cycle N: done=1 only in cycle N+33; result=0xFFFFFFEB; rd_out=rd_in; busy high N+1..N+33.
- MULHU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE. MULH 0x80000000*0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFF.
- DIV -7/2 gives 0xFFFFFFFD; REM -7%2 gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100%7 gives 2.
- DIVU 5/0 gives 0xFFFFFFFF and REM 5%0 gives 5, with done in N+1. DIV 0x80000000/-1 gives 0x80000000 and REM gives 0, with done in N+1.
- Second start pulsed in cycle N+10 with different operands: ignored; first result delivered at N+33, with no second done.
- flush in cycle N+5: busy=0 in N+6; no done appears; result retains its prior value. A new start at N+6 completes at N+39.
